// File: rtl/button_command_gen.sv
// button_command_gen: two debounced auto-repeat buttons driving single-cycle inc/dec commands with an amount
// Ports: clk, reset (sync, active high); btn_inc, btn_dec, sw_amount[7:0] raw async inputs;
//        increment, decrement one-cycle commands; amount[7:0] valid whenever a command is high.
module button_command_gen #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic [7:0] sw_amount,
   output logic       increment,
   output logic       decrement,
   output logic [7:0] amount
);
   localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TW = $clog2(RMAX);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] RP_LAST = TW'(REPEAT_PERIOD - 1);
   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
   logic [1:0] btn_s1, btn_s2, db, req;
   logic [7:0] sw_s1, sw_s2;
   logic [DW-1:0] db_cnt [2];
   logic [TW-1:0] timer [2];
   state_t state [2];
   logic fire_inc, fire_dec;
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_s1 <= '0;
         btn_s2 <= '0;
         sw_s1 <= '0;
         sw_s2 <= '0;
      end else begin
         btn_s1 <= {btn_dec, btn_inc};
         btn_s2 <= btn_s1;
         sw_s1 <= sw_amount;
         sw_s2 <= sw_s1;
      end
   end
   // index 0 is the increment button, index 1 the decrement button
   always_comb begin
      req = '0;
      for (int i = 0; i < 2; i++)
         req[i] = db[i] && (state[i] == IDLE || (state[i] == DELAY && timer[i] == RD_LAST) ||
                            (state[i] == REPEAT && timer[i] == RP_LAST));
   end
   // a request implies its own button is down, so checking the other button's state covers both conflict cases
   assign fire_inc = req[0] && !db[1];
   assign fire_dec = req[1] && !db[0];
   always_ff @(posedge clk) begin
      if (reset) begin
         db <= '0;
         for (int i = 0; i < 2; i++) begin
            db_cnt[i] <= '0;
            timer[i] <= '0;
            state[i] <= IDLE;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (btn_s2[i] == db[i]) db_cnt[i] <= '0;
            else if (db_cnt[i] == DB_LAST) begin
               db[i] <= btn_s2[i];
               db_cnt[i] <= '0;
            end else db_cnt[i] <= db_cnt[i] + 1'b1;
            if (!db[i]) begin
               state[i] <= IDLE;
               timer[i] <= '0;
            end else if (req[i]) begin
               state[i] <= state[i] == IDLE ? DELAY : REPEAT;
               timer[i] <= '0;
            end else timer[i] <= timer[i] + 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         increment <= 1'b0;
         decrement <= 1'b0;
         amount <= '0;
      end else begin
         increment <= fire_inc;
         decrement <= fire_dec;
         if (fire_inc || fire_dec) amount <= sw_s2;
      end
   end
endmodule

// File: tb/tb_button_command_gen.sv
// tb_button_command_gen: edge-history model of button_command_gen plus directed literal checks
module tb_button_command_gen;
   localparam int D = 4, RD = 10, RP = 4;
   logic clk = 0, reset = 1, btn_inc = 1, btn_dec = 0;
   logic [7:0] sw_amount = 8'h05;
   logic increment, decrement;
   logic [7:0] amount;
   int errors = 0, checks = 0;
   button_command_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
      .clk(clk), .reset(reset), .btn_inc(btn_inc), .btn_dec(btn_dec), .sw_amount(sw_amount),
      .increment(increment), .decrement(decrement), .amount(amount));
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // model: raw[n]/rsw[n] are inputs sampled at edge n; the synchronised value used at edge n is raw[n-2]
   bit [1:0] raw [1024];
   bit [7:0] rsw [1024];
   int n = 10;
   int press [2];
   bit [1:0] mdb;
   bit e_inc, e_dec, started;
   bit [7:0] e_amt;
   always @(posedge clk) begin
      bit [1:0] rq;
      bit flip;
      int d;
      n++;
      started = 1;
      if (reset) begin
         raw[n] = 0; raw[n-1] = 0; rsw[n] = 0; rsw[n-1] = 0;
         mdb = 0; e_inc = 0; e_dec = 0; e_amt = 0;
      end else begin
         raw[n] = {btn_dec, btn_inc};
         rsw[n] = sw_amount;
         for (int b = 0; b < 2; b++) begin
            d = n - 1 - press[b];
            rq[b] = mdb[b] && (d == 0 || d == RD || (d > RD && (d - RD) % RP == 0));
         end
         e_inc = rq[0] && !mdb[1];
         e_dec = rq[1] && !mdb[0];
         if (e_inc || e_dec) e_amt = rsw[n-2];
         for (int b = 0; b < 2; b++) begin
            flip = 1;
            for (int j = 0; j < D; j++) if (raw[n-2-j][b] == mdb[b]) flip = 0;
            if (flip) begin
               mdb[b] = !mdb[b];
               if (mdb[b]) press[b] = n;
            end
         end
      end
   end
   always @(negedge clk) if (started) begin
      check("model_inc", {7'b0, increment}, {7'b0, e_inc});
      check("model_dec", {7'b0, decrement}, {7'b0, e_dec});
      check("model_amount", amount, e_amt);
      check("exclusive", {7'b0, increment && decrement}, 8'h00);
   end
   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   initial begin
      repeat (4) @(negedge clk);
      check("reset_inc", {7'b0, increment}, 8'h00);
      check("reset_dec", {7'b0, decrement}, 8'h00);
      check("reset_amount", amount, 8'h00);
      reset = 0;
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         check("t1_inc", {7'b0, increment}, {7'b0, j == 7});
         if (j == 7) check("t1_amount", amount, 8'h05);
         if (j == 7) check("t1_model", {7'b0, e_inc}, 8'h01);
         if (j == 7) btn_inc = 0;
      end
      repeat (10) @(negedge clk);
      btn_inc = 1;
      repeat (3) @(negedge clk);
      btn_inc = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         check("t2_bounce", {7'b0, increment}, 8'h00);
      end
      sw_amount = 8'h0A;
      btn_inc = 1;
      for (int j = 1; j <= 32; j++) begin
         @(negedge clk);
         check("t2_inc", {7'b0, increment}, {7'b0, j == 7 || j == 17 || j == 21 || j == 25});
         if (increment) check("t2_amount", amount, 8'h0A);
         if (j == 20) btn_inc = 0;
      end
      sw_amount = 8'h03;
      btn_dec = 1;
      for (int j = 1; j <= 25; j++) begin
         @(negedge clk);
         check("t3_dec", {7'b0, decrement}, {7'b0, j == 7});
         if (j == 7) check("t3_amount", amount, 8'h03);
         if (j == 8) btn_dec = 0;
      end
      btn_inc = 1;
      btn_dec = 1;
      sw_amount = 8'h77;
      for (int j = 1; j <= 42; j++) begin
         @(negedge clk);
         check("t4_inc", {7'b0, increment}, 8'h00);
         check("t4_dec", {7'b0, decrement}, 8'h00);
         check("t4_amount", amount, 8'h03);
         if (j == 30) begin
            btn_inc = 0;
            btn_dec = 0;
         end
      end
      sw_amount = 8'h01;
      btn_inc = 1;
      for (int j = 1; j <= 25; j++) begin
         @(negedge clk);
         if (j < 25) check("t5_inc", {7'b0, increment}, {7'b0, j == 7 || j == 17 || j == 21});
         if (j == 17) check("t5_amount_old", amount, 8'h01);
         if (j == 17) sw_amount = 8'hFF;
         if (j == 21) check("t5_amount_new", amount, 8'hFF);
         if (j == 24) begin
            reset = 1;
            btn_inc = 0;
         end
      end
      check("t5_rst_inc", {7'b0, increment}, 8'h00);
      check("t5_rst_dec", {7'b0, decrement}, 8'h00);
      check("t5_rst_amount", amount, 8'h00);
      @(negedge clk);
      reset = 0;
      repeat (20) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
